// File: rtl/serial_arith_pkg.sv
// ============================================================================
// serial_arith_pkg : shared types and limits for the bit-serial arithmetic
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned c_WIDTH_MIN = 1;
  localparam int unsigned c_WIDTH_MAX = 32;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_bit.sv
// ============================================================================
// full_subtractor_bit : one-bit subtract cell, d = a - b - bin
// Rev 1.0
// ============================================================================
`default_nettype none

module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : LSB-first bit-serial a - b with valid/ready handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned c_CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;

  logic               w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_shift;

  full_subtractor_bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB so the LSB-first result ends aligned.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_shift = w_d;
    end else begin : g_res_wn
      assign w_res_shift = {w_d, res_q[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (cnt_q == c_CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = w_res_shift;
        br_d  = w_bout;
        cnt_d = cnt_q + c_CNT_W'(1);
        // Outputs load only on the final bit, so partial results never show.
        if (w_last) begin
          diff_d   = w_res_shift;
          borrow_d = w_bout;
          ovf_d    = (a_msb_q != b_msb_q) & (w_d != a_msb_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed and exhaustive checks of serial_subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, br8, of8;
  logic [7:0] d8;

  logic       iv4 = 1'b0, or4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, br4, of4;
  logic [3:0] d4;

  bit sweep = 1'b0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow(br8), .overflow(of8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(br4), .overflow(of4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {overflow, borrow, diff} from plain integer arithmetic.
  function automatic logic [33:0] model(input longint a, input longint b, input int w);
    longint m, d, sa, sb, sd;
    logic   brw, ovf;
    m   = 1;
    m   = m << w;
    d   = ((a - b) % m + m) % m;
    brw = (a < b);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sd  = sa - sb;
    ovf = (sd < -(m / 2)) || (sd >= m / 2);
    return {ovf, brw, d[31:0]};
  endfunction

  bit          busy[2], acc_pend[2], prev_ov[2], prev_or[2];
  int          lat[2];
  longint      pa[2], pb[2];
  logic [33:0] e[2], last[2];

  task automatic mon(input int i, input int w, input string tg,
                     input logic ov, input logic ir, input logic iv, input logic orr,
                     input longint a, input longint b, input longint d,
                     input logic brw, input logic ovf);
    logic [33:0] got;
    got = {ovf, brw, d[31:0]};
    if (!rst_n) begin
      chk({tg, "_rst_out_valid"}, ov, 0);
      chk({tg, "_rst_in_ready"}, ir, 1);
      chk({tg, "_rst_outputs"}, got, 0);
      busy[i] = 0; acc_pend[i] = 0; prev_ov[i] = 0; prev_or[i] = 0;
      last[i] = '0;
      return;
    end
    if (busy[i]) lat[i]++;
    if (acc_pend[i]) begin
      busy[i] = 1;
      lat[i]  = 0;
      e[i]    = model(pa[i], pb[i], w);
    end
    if (prev_ov[i] && prev_or[i]) chk({tg, "_out_valid_drop"}, ov, 0);
    if (ov) begin
      chk({tg, "_in_ready_while_valid"}, ir, 0);
      if (!prev_ov[i]) begin
        chk({tg, "_valid_expected"}, busy[i], 1);
        chk({tg, "_latency"}, lat[i], w);
        chk({tg, "_result"}, got, e[i]);
        last[i] = e[i];
        busy[i] = 0;
      end else begin
        chk({tg, "_backpressure_hold"}, got, last[i]);
      end
    end else begin
      chk({tg, "_idle_hold"}, got, last[i]);
      if (busy[i]) begin
        chk({tg, "_in_ready_busy"}, ir, 0);
        if (lat[i] >= w) chk({tg, "_late"}, lat[i], w - 1);
      end else begin
        chk({tg, "_in_ready_idle"}, ir, 1);
      end
    end
    acc_pend[i] = iv & ir;
    pa[i] = a;
    pb[i] = b;
    prev_ov[i] = ov;
    prev_or[i] = orr;
  endtask

  always @(negedge clk) begin
    mon(0, 8, "w8", ov8, ir8, iv8, or8, a8, b8, d8, br8, of8);
    mon(1, 4, "w4", ov4, ir4, iv4, or4, a4, b4, d4, br4, of4);
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    a8 = a; b8 = b; iv8 = 1'b1;
    while (!ir8 && t < 100) begin @(posedge clk); #1; t++; end
    chk("w8_accept_wait", (t < 100), 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic finish8(input int hold, input logic [7:0] ed, input logic eb, input logic eo);
    int t;
    t = 0;
    or8 = (hold == 0);
    while (!ov8 && t < 100) begin @(posedge clk); #1; t++; end
    chk("w8_done_wait", ov8, 1);
    chk("w8_dir_diff", d8, ed);
    chk("w8_dir_borrow", br8, eb);
    chk("w8_dir_overflow", of8, eo);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("w8_bp_in_ready", ir8, 0);
        chk("w8_bp_out_valid", ov8, 1);
        chk("w8_bp_diff", d8, ed);
      end
      or8 = 1'b1;
    end
    @(posedge clk); #1;
    chk("w8_handshake_drop", ov8, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk); #1;
    if (sweep) or4 = 1'($urandom_range(0, 1));
  end

  initial begin
    int t;
    chk("pin_model_05_03", model(8'h05, 8'h03, 8), {1'b0, 1'b0, 32'h02});
    chk("pin_model_03_05", model(8'h03, 8'h05, 8), {1'b0, 1'b1, 32'hFE});
    chk("pin_model_80_01", model(8'h80, 8'h01, 8), {1'b1, 1'b0, 32'h7F});
    chk("pin_model_7F_FF", model(8'h7F, 8'hFF, 8), {1'b1, 1'b1, 32'h80});
    chk("pin_model_w4_0_8", model(0, 8, 4), {1'b1, 1'b1, 32'h8});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", ir8, 1);
    chk("reset_out_valid", ov8, 0);
    chk("reset_diff", d8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start8(8'h05, 8'h03); finish8(0, 8'h02, 1'b0, 1'b0);
    start8(8'h03, 8'h05); finish8(0, 8'hFE, 1'b1, 1'b0);
    start8(8'h80, 8'h01); finish8(0, 8'h7F, 1'b0, 1'b1);
    start8(8'h7F, 8'hFF); finish8(0, 8'h80, 1'b1, 1'b1);

    // Backpressure with the next operands already presented.
    start8(8'h11, 8'h22);
    a8 = 8'h40; b8 = 8'h10; iv8 = 1'b1;
    finish8(5, 8'hEF, 1'b1, 1'b0);
    start8(8'h40, 8'h10); finish8(0, 8'h30, 1'b0, 1'b0);

    // Abort in the 4th shift cycle.
    start8(8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", ir8, 1);
    chk("abort_out_valid", ov8, 0);
    chk("abort_diff", d8, 0);
    chk("abort_borrow", br8, 0);
    chk("abort_overflow", of8, 0);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_valid", ov8, 0);
    end
    start8(8'hAA, 8'h55); finish8(0, 8'h55, 1'b0, 1'b1);

    // Exhaustive WIDTH=4 sweep under random backpressure.
    sweep = 1'b1;
    iv4 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a); b4 = 4'(b);
        t = 0;
        while (!ir4 && t < 200) begin @(posedge clk); #1; t++; end
        chk("w4_accept_wait", (t < 200), 1);
        @(posedge clk); #1;
      end
    end
    iv4 = 1'b0;
    t = 0;
    while (!ir4 && t < 200) begin @(posedge clk); #1; t++; end
    chk("w4_final_wait", (t < 200), 1);
    sweep = 1'b0;
    or4 = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
